// File: rtl/bridge_rx.sv
// bridge_rx: parses ASCII R/W commands from the UART byte stream and issues
// single-cycle register-bus transactions.
module bridge_rx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic [15:0] addr_o,
    output logic [15:0] wdata_o,
    output logic        rw_o,
    output logic        valid_o
);
    localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, TERM = 2'd3;
    logic [1:0]  state, cnt;
    logic [15:0] abuf, dbuf;
    logic        rw_q, is_dig, is_hex, is_term, is_cmd;
    logic [3:0]  nib;
    always_comb begin
        is_dig  = data_i >= 8'h30 && data_i <= 8'h39;
        is_hex  = is_dig || (data_i >= 8'h41 && data_i <= 8'h46) || (data_i >= 8'h61 && data_i <= 8'h66);
        // letters A-F/a-f have low nibble 1..6, so adding 9 yields 10..15
        nib     = is_dig ? data_i[3:0] : data_i[3:0] + 4'd9;
        is_term = data_i == 8'h0D || data_i == 8'h0A;
        is_cmd  = data_i == 8'h52 || data_i == 8'h57;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            abuf    <= 16'h0;
            dbuf    <= 16'h0;
            rw_q    <= 1'b0;
            addr_o  <= 16'h0;
            wdata_o <= 16'h0;
            rw_o    <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (valid_i) begin
                if (is_cmd) begin
                    state <= ADDR;
                    rw_q  <= data_i == 8'h57;
                    cnt   <= 2'd0;
                    abuf  <= 16'h0;
                    dbuf  <= 16'h0;
                end else begin
                    case (state)
                        ADDR: if (is_hex) begin
                            abuf <= {abuf[11:0], nib};
                            cnt  <= cnt + 2'd1;
                            if (cnt == 2'd3) state <= rw_q ? DATA : TERM;
                        end else state <= IDLE;
                        DATA: if (is_hex) begin
                            dbuf <= {dbuf[11:0], nib};
                            cnt  <= cnt + 2'd1;
                            if (cnt == 2'd3) state <= TERM;
                        end else state <= IDLE;
                        TERM: begin
                            state <= IDLE;
                            if (is_term) begin
                                addr_o  <= abuf;
                                wdata_o <= rw_q ? dbuf : 16'h0;
                                rw_o    <= rw_q;
                                valid_o <= 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_bridge_rx.sv
// tb_bridge_rx: table-driven byte vectors with expected bus outputs, plus
// hand-written reset sequences.
module tb_bridge_rx;
    logic        clk = 1'b0, rst_n = 1'b0, valid_i = 1'b0;
    logic [7:0]  data_i = 8'h0;
    logic [15:0] addr_o, wdata_o;
    logic        rw_o, valid_o;

    bridge_rx dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
        .addr_o(addr_o), .wdata_o(wdata_o), .rw_o(rw_o), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic        v;
        logic        ev;
        logic [15:0] ea;
        logic [15:0] ew;
        logic        er;
    } vec_t;

    vec_t        vq[$];
    logic [15:0] h_a = 16'h0, h_w = 16'h0;
    logic        h_r = 1'b0;
    int          checks = 0, errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [7:0] d, input logic v, input logic ev);
        vq.push_back('{d, v, ev, h_a, h_w, h_r});
    endfunction

    function automatic void add_str(input string s);
        for (int i = 0; i < s.len(); i++) add(s[i], 1'b1, 1'b0);
    endfunction

    function automatic void add_term(input logic [7:0] t, input logic [15:0] a, input logic [15:0] w, input logic r);
        h_a = a; h_w = w; h_r = r;
        add(t, 1'b1, 1'b1);
    endfunction

    task automatic step(input logic [7:0] d, input logic v);
        data_i = d; valid_i = v;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [15:0] ea, input logic [15:0] ew, input logic er);
        chk({tag, " valid_o"}, {15'h0, valid_o}, {15'h0, ev});
        chk({tag, " addr_o"}, addr_o, ea);
        chk({tag, " wdata_o"}, wdata_o, ew);
        chk({tag, " rw_o"}, {15'h0, rw_o}, {15'h0, er});
    endtask

    task automatic send_quiet(input string s, input string tag);
        for (int i = 0; i < s.len(); i++) begin
            step(s[i], 1'b1);
            chk($sformatf("%s byte%0d valid_o", tag, i), {15'h0, valid_o}, 16'h0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 16'h0, 16'h0, 1'b0);
        rst_n = 1'b1;

        // simple read; trailing LF must not pulse again
        add_str("R0003"); add_term(8'h0D, 16'h0003, 16'h0, 1'b0); add(8'h0A, 1'b1, 1'b0);
        // mixed-case write
        add_str("W000aBeEf"); add_term(8'h0A, 16'h000A, 16'hBEEF, 1'b1); add(8'h00, 1'b0, 1'b0);
        // malformed commands, then a good read
        add_str("R12"); add(8'h0D, 1'b1, 1'b0);
        add_str("R12345"); add(8'h0D, 1'b1, 1'b0);
        add_str("W00G0");
        add_str("R0010"); add_term(8'h0D, 16'h0010, 16'h0, 1'b0);
        // write then restart mid-write into a read
        add_str("W12345678"); add_term(8'h0A, 16'h1234, 16'h5678, 1'b1);
        add_str("W00R0007"); add_term(8'h0D, 16'h0007, 16'h0, 1'b0);
        // data_i changes while valid_i is low must be ignored
        add_str("W00");
        add(8'h52, 1'b0, 1'b0); add(8'h0D, 1'b0, 1'b0); add(8'h47, 1'b0, 1'b0); add(8'h35, 1'b0, 1'b0);
        add_str("010002"); add_term(8'h0D, 16'h0001, 16'h0002, 1'b1);
        // back-to-back writes, pulses 10 cycles apart
        add_str("W00030008"); add_term(8'h0D, 16'h0003, 16'h0008, 1'b1);
        add_str("W00040001"); add_term(8'h0D, 16'h0004, 16'h0001, 1'b1);
        add(8'h00, 1'b0, 1'b0);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].d, vq[i].v);
            check_out($sformatf("vec%0d", i), vq[i].ev, vq[i].ea, vq[i].ew, vq[i].er);
        end

        // asynchronous reset mid-command clears outputs before the next edge
        send_quiet("W00", "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        // partial command was discarded: stray digits and CR do nothing
        send_quiet("00000000", "post_rst");
        step(8'h0D, 1'b1);
        check_out("post_rst cr", 1'b0, 16'h0, 16'h0, 1'b0);
        send_quiet("R0001", "rd1");
        step(8'h0D, 1'b1);
        check_out("rd1 term", 1'b1, 16'h0001, 16'h0, 1'b0);
        step(8'h00, 1'b0);
        check_out("rd1 after", 1'b0, 16'h0001, 16'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
